snax_accel_shell_ctrl: RTL and testbench

SNAX_ACCEL_SHELL_CTRL -- requirements
Module: snax_accel_shell_ctrl

---
 rtl/snax_accel_shell_pkg.sv | 24 ++
 rtl/snax_sat_counter.sv | 44 ++++
 rtl/snax_accel_shell_ctrl.sv | 146 ++++++++++++++
 tb/tb_snax_accel_shell_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snax_accel_shell_pkg.sv
// Shared types for the accelerator shell controller: FSM state encoding,
// status-word indices and a helper for sizing per-cycle beat counts.
// Pure declarations; no logic, no latency, no flow control.
package snax_accel_shell_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CFG   = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Read-only status word layout
    localparam int unsigned RoStatus  = 0;
    localparam int unsigned RoCycles  = 1;
    localparam int unsigned RoWrBeats = 2;
    localparam int unsigned RoRdBeats = 3;

    // Bits needed to hold any value in 0..n
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/snax_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count visible one cycle after the increment is presented.
// Backpressure: none; sticks at all-ones instead of wrapping.
// Ports: clk_i/rst_ni (sync active-low), clr_i, inc_i (amount to add), cnt_o.
module snax_sat_counter #(
    parameter int unsigned Width    = 32,
    parameter int unsigned IncWidth = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic [IncWidth-1:0] inc_i,
    output logic [Width-1:0]    cnt_o
);

    // One extra bit so an overflowing sum is detectable before clamping
    localparam int unsigned SumWidth = ((Width > IncWidth) ? Width : IncWidth) + 1;

    logic [Width-1:0]    cnt_q;
    logic [Width-1:0]    cnt_d;
    logic [SumWidth-1:0] sum;

    always_comb begin
        sum = SumWidth'(cnt_q) + SumWidth'(inc_i);
        if (clr_i) begin
            cnt_d = '0;
        end else if (sum > SumWidth'({Width{1'b1}})) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[Width-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/snax_accel_shell_ctrl.sv
// Accelerator shell controller: CSR launch -> config handshake -> busy -> drain -> done.
// Latency: cfg_valid_o one cycle after launch; done_o on the last of DrainCycles drain cycles.
// Backpressure: CSR ready only while idle; config held stable until cfg_ready_i.
// Ports: csr_reg_set_* launch handshake, csr_reg_ro_set_o status, cfg_* accelerator config,
//        acc_busy_i, rd_/wr_ valid/ready observed stream handshakes, done_o completion pulse.
module snax_accel_shell_ctrl
    import snax_accel_shell_pkg::*;
#(
    parameter int unsigned NumRd        = 14,
    parameter int unsigned NumWr        = 4,
    parameter int unsigned RegRWCount   = 8,
    parameter int unsigned RegROCount   = 4,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned DrainCycles  = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_i,
    input  logic                                     csr_reg_set_valid_i,
    output logic                                     csr_reg_set_ready_o,
    output logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_o,
    output logic [RegRWCount-2:0][RegDataWidth-1:0]  cfg_data_o,
    output logic                                     cfg_valid_o,
    input  logic                                     cfg_ready_i,
    input  logic                                     acc_busy_i,
    input  logic [NumRd-1:0]                         rd_valid_i,
    input  logic [NumRd-1:0]                         rd_ready_i,
    input  logic [NumWr-1:0]                         wr_valid_i,
    input  logic [NumWr-1:0]                         wr_ready_i,
    output logic                                     done_o
);

    localparam int unsigned RdPopW = cnt_width(NumRd);
    localparam int unsigned WrPopW = cnt_width(NumWr);
    localparam int unsigned DrainW = cnt_width(DrainCycles);

    state_e                                 state_q, state_d;
    logic [RegRWCount-2:0][RegDataWidth-1:0] cfg_data_q;
    logic [RegDataWidth-1:0]                exp_q;
    logic [DrainW-1:0]                      drain_cnt_q;
    logic                                   busy_first_q;

    logic                    launch;
    logic                    count_en;
    logic                    drain_last;
    logic [RdPopW-1:0]       rd_pop;
    logic [WrPopW-1:0]       wr_pop;
    logic [RegDataWidth:0]   wr_sum;
    logic [RegDataWidth-1:0] cyc_cnt, wr_cnt, rd_cnt;

    assign launch     = csr_reg_set_valid_i && (state_q == ST_IDLE);
    assign count_en   = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
    assign drain_last = (drain_cnt_q == DrainW'(DrainCycles - 1));

    always_comb begin
        rd_pop = '0;
        for (int i = 0; i < NumRd; i++) begin
            rd_pop = rd_pop + RdPopW'(rd_valid_i[i] & rd_ready_i[i]);
        end
        wr_pop = '0;
        for (int i = 0; i < NumWr; i++) begin
            wr_pop = wr_pop + WrPopW'(wr_valid_i[i] & wr_ready_i[i]);
        end
    end

    // Beat total including this cycle's beats, so completion is seen the same cycle
    assign wr_sum = (RegDataWidth+1)'(wr_cnt) + (RegDataWidth+1)'(wr_pop);

    // State register and launch-time data
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cfg_data_q   <= '0;
            exp_q        <= '0;
            drain_cnt_q  <= '0;
            busy_first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                cfg_data_q <= csr_reg_set_i[RegRWCount-2:0];
                exp_q      <= csr_reg_set_i[RegRWCount-1];
            end
            // Masks acc_busy_i in the first BUSY cycle: the accelerator may not
            // have raised busy yet right after accepting its config.
            busy_first_q <= (state_q == ST_CFG) && (state_d == ST_BUSY);
            drain_cnt_q  <= (state_q == ST_DRAIN) ? drain_cnt_q + DrainW'(1) : '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (launch) state_d = ST_CFG;
            ST_CFG:   if (cfg_ready_i) state_d = ST_BUSY;
            ST_BUSY: begin
                if (exp_q != '0) begin
                    if (wr_sum >= {1'b0, exp_q}) state_d = ST_DRAIN;
                end else if (!busy_first_q && !acc_busy_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (drain_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: all derived from registered state only
    always_comb begin
        csr_reg_set_ready_o = (state_q == ST_IDLE);
        cfg_valid_o         = (state_q == ST_CFG);
        done_o              = (state_q == ST_DRAIN) && drain_last;
        csr_reg_ro_set_o    = '0;
        csr_reg_ro_set_o[RoStatus]  = {{(RegDataWidth-1){1'b0}}, (state_q != ST_IDLE)};
        csr_reg_ro_set_o[RoCycles]  = cyc_cnt;
        csr_reg_ro_set_o[RoWrBeats] = wr_cnt;
        csr_reg_ro_set_o[RoRdBeats] = rd_cnt;
    end

    assign cfg_data_o = cfg_data_q;

    snax_sat_counter #(.Width(RegDataWidth), .IncWidth(1)) u_cyc_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (launch),
        .inc_i  (state_q != ST_IDLE),
        .cnt_o  (cyc_cnt)
    );

    snax_sat_counter #(.Width(RegDataWidth), .IncWidth(WrPopW)) u_wr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (launch),
        .inc_i  (count_en ? wr_pop : '0),
        .cnt_o  (wr_cnt)
    );

    snax_sat_counter #(.Width(RegDataWidth), .IncWidth(RdPopW)) u_rd_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (launch),
        .inc_i  (count_en ? rd_pop : '0),
        .cnt_o  (rd_cnt)
    );

endmodule

// File: tb/tb_snax_accel_shell_ctrl.sv
// Testbench for snax_accel_shell_ctrl: directed launches with hand-computed
// cycle/beat totals pushed to a scoreboard, checked by a monitor on done_o
// and on each config handshake.
module tb_snax_accel_shell_ctrl;
    import snax_accel_shell_pkg::*;

    localparam int RW  = 8;
    localparam int RO  = 4;
    localparam int DW  = 32;
    localparam int NRD = 14;
    localparam int NWR = 4;
    localparam int NDW = 4;

    logic                   clk;
    logic                   rst_ni;
    logic [RW-1:0][DW-1:0]  csr_set;
    logic                   csr_vld;
    logic                   csr_rdy;
    logic [RO-1:0][DW-1:0]  ro;
    logic [RW-2:0][DW-1:0]  cfg_dat;
    logic                   cfg_vld;
    logic                   cfg_rdy;
    logic                   acc_busy;
    logic [NRD-1:0]         rd_vld, rd_rdy;
    logic [NWR-1:0]         wr_vld, wr_rdy;
    logic                   done;

    // Narrow instance for saturation
    logic [RW-1:0][NDW-1:0] n_set;
    logic                   n_vld, n_rdy;
    logic [RO-1:0][NDW-1:0] n_ro;
    logic [RW-2:0][NDW-1:0] n_cfg;
    logic                   n_cfg_vld, n_cfg_rdy, n_busy;
    logic [NRD-1:0]         n_rd_vld, n_rd_rdy;
    logic [NWR-1:0]         n_wr_vld, n_wr_rdy;
    logic                   n_done;

    snax_accel_shell_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .csr_reg_set_i(csr_set), .csr_reg_set_valid_i(csr_vld), .csr_reg_set_ready_o(csr_rdy),
        .csr_reg_ro_set_o(ro),
        .cfg_data_o(cfg_dat), .cfg_valid_o(cfg_vld), .cfg_ready_i(cfg_rdy),
        .acc_busy_i(acc_busy),
        .rd_valid_i(rd_vld), .rd_ready_i(rd_rdy),
        .wr_valid_i(wr_vld), .wr_ready_i(wr_rdy),
        .done_o(done)
    );

    snax_accel_shell_ctrl #(.RegDataWidth(NDW)) dut_n (
        .clk_i(clk), .rst_ni(rst_ni),
        .csr_reg_set_i(n_set), .csr_reg_set_valid_i(n_vld), .csr_reg_set_ready_o(n_rdy),
        .csr_reg_ro_set_o(n_ro),
        .cfg_data_o(n_cfg), .cfg_valid_o(n_cfg_vld), .cfg_ready_i(n_cfg_rdy),
        .acc_busy_i(n_busy),
        .rd_valid_i(n_rd_vld), .rd_ready_i(n_rd_rdy),
        .wr_valid_i(n_wr_vld), .wr_ready_i(n_wr_rdy),
        .done_o(n_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] wr;
        logic [31:0] rd;
    } res_t;

    res_t        sb_q[$];
    logic [31:0] cfg_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a launch for one cycle; config words are base+i, last word is E
    task automatic launch(input logic [31:0] e, input logic [31:0] base, input bit push,
                          input logic [31:0] cyc, input logic [31:0] wr, input logic [31:0] rd);
        for (int i = 0; i < RW - 1; i++) csr_set[i] = base + 32'(i);
        csr_set[RW-1] = e;
        csr_vld = 1'b1;
        cfg_q.push_back(base);
        if (push) sb_q.push_back({cyc, wr, rd});
        tick();
        csr_vld = 1'b0;
    endtask

    // Monitor: config words on each config handshake, totals the cycle after done
    res_t        pend;
    bit          pend_vld = 1'b0;
    logic [31:0] cfg_exp;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (cfg_vld && cfg_rdy) begin
                chk("cfg_expected", 32'(cfg_q.size() != 0), 32'd1);
                if (cfg_q.size() != 0) begin
                    cfg_exp = cfg_q.pop_front();
                    chk("cfg_word0", cfg_dat[0], cfg_exp);
                    chk("cfg_word_last", cfg_dat[RW-2], cfg_exp + 32'd6);
                end
            end
            if (pend_vld) begin
                chk("ro_cycles", ro[RoCycles], pend.cyc);
                chk("ro_wr_beats", ro[RoWrBeats], pend.wr);
                chk("ro_rd_beats", ro[RoRdBeats], pend.rd);
                chk("ro_status_idle", ro[RoStatus], 32'd0);
                pend_vld = 1'b0;
            end
            if (done) begin
                chk("done_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    pend     = sb_q.pop_front();
                    pend_vld = 1'b1;
                end
            end
        end
    end

    initial begin
        bit seen;
        rst_ni = 1'b0; csr_set = '0; csr_vld = 1'b0; cfg_rdy = 1'b0; acc_busy = 1'b0;
        rd_vld = '0; rd_rdy = '0; wr_vld = '0; wr_rdy = '0;
        n_set = '0; n_vld = 1'b0; n_cfg_rdy = 1'b0; n_busy = 1'b0;
        n_rd_vld = '0; n_rd_rdy = '0; n_wr_vld = '0; n_wr_rdy = '0;
        repeat (3) tick();

        // Reset state
        for (int i = 0; i < RO; i++) chk("reset_ro", ro[i], 32'd0);
        chk("reset_ready", 32'(csr_rdy), 32'd1);
        chk("reset_cfg_valid", 32'(cfg_vld), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_cfg_data", cfg_dat[0], 32'd0);
        rst_ni = 1'b1;
        tick();

        // E=3, cfg_ready one cycle late, 1 write + 2 read beats per cycle
        launch(32'd3, 32'h100, 1'b1, 32'd7, 32'd3, 32'd6);
        tick();
        cfg_rdy = 1'b1;
        tick();
        cfg_rdy = 1'b0;
        wr_vld = 4'b0001; wr_rdy = 4'b0001;
        rd_vld = 14'h0021; rd_rdy = 14'h0021;
        repeat (3) tick();
        wr_vld = '0; wr_rdy = '0; rd_vld = '0; rd_rdy = '0;
        chk("t1_done_early", 32'(done), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd1);
        tick();
        chk("t1_done_clear", 32'(done), 32'd0);
        chk("t1_idle_ready", 32'(csr_rdy), 32'd1);

        // E=4, two beats in each of two consecutive cycles
        launch(32'd4, 32'h200, 1'b1, 32'd5, 32'd4, 32'd0);
        cfg_rdy = 1'b1;
        tick();
        cfg_rdy = 1'b0;
        wr_vld = 4'b0011; wr_rdy = 4'b0011;
        tick();
        wr_vld = 4'b1100; wr_rdy = 4'b1110;
        tick();
        wr_vld = '0; wr_rdy = '0;
        chk("t2_done_early", 32'(done), 32'd0);
        tick();
        chk("t2_done_pulse", 32'(done), 32'd1);
        tick();

        // E=0, busy for 10 BUSY cycles then low; beats during CFG are ignored
        launch(32'd0, 32'h300, 1'b1, 32'd14, 32'd0, 32'd0);
        cfg_rdy = 1'b1; acc_busy = 1'b1;
        wr_vld = 4'b0001; wr_rdy = 4'b0001; rd_vld = 14'h1; rd_rdy = 14'h1;
        tick();
        cfg_rdy = 1'b0;
        wr_vld = '0; wr_rdy = '0; rd_vld = '0; rd_rdy = '0;
        repeat (10) tick();
        acc_busy = 1'b0;
        tick();
        chk("t3_done_early", 32'(done), 32'd0);
        tick();
        chk("t3_done_pulse", 32'(done), 32'd1);
        tick();

        // CSR valid held during BUSY: not accepted until back in IDLE
        launch(32'd0, 32'h400, 1'b1, 32'd6, 32'd0, 32'd0);
        cfg_rdy = 1'b1; acc_busy = 1'b1;
        tick();
        cfg_rdy = 1'b0;
        for (int i = 0; i < RW - 1; i++) csr_set[i] = 32'h500 + 32'(i);
        csr_set[RW-1] = 32'd2;
        csr_vld = 1'b1;
        cfg_q.push_back(32'h500);
        sb_q.push_back({32'd4, 32'd2, 32'd0});
        chk("t4_busy_ready0", 32'(csr_rdy), 32'd0);
        tick();
        chk("t4_busy_ready1", 32'(csr_rdy), 32'd0);
        tick();
        acc_busy = 1'b0;
        chk("t4_no_relatch", cfg_dat[0], 32'h400);
        tick();
        chk("t4_drain_ready", 32'(csr_rdy), 32'd0);
        tick();
        chk("t4_done_pulse", 32'(done), 32'd1);
        tick();
        chk("t4_idle_ready", 32'(csr_rdy), 32'd1);
        tick();
        csr_vld = 1'b0;
        chk("t4_relaunch_cfg", 32'(cfg_vld), 32'd1);
        cfg_rdy = 1'b1;
        tick();
        cfg_rdy = 1'b0;
        wr_vld = 4'b1010; wr_rdy = 4'b1010;
        tick();
        wr_vld = '0; wr_rdy = '0;
        tick();
        chk("t4b_done_pulse", 32'(done), 32'd1);
        tick();

        // Reset mid-BUSY: no done, everything cleared, immediate relaunch
        launch(32'd5, 32'h600, 1'b0, 32'd0, 32'd0, 32'd0);
        cfg_rdy = 1'b1;
        tick();
        cfg_rdy = 1'b0;
        wr_vld = 4'b0001; wr_rdy = 4'b0001; rd_vld = 14'h2; rd_rdy = 14'h2;
        tick();
        wr_vld = '0; wr_rdy = '0; rd_vld = '0; rd_rdy = '0;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < RO; i++) chk("t5_reset_ro", ro[i], 32'd0);
        chk("t5_reset_done", 32'(done), 32'd0);
        chk("t5_reset_ready", 32'(csr_rdy), 32'd1);
        chk("t5_reset_cfg_valid", 32'(cfg_vld), 32'd0);
        chk("t5_reset_cfg_data", cfg_dat[0], 32'd0);
        launch(32'd1, 32'h700, 1'b1, 32'd4, 32'd1, 32'd0);
        cfg_rdy = 1'b1;
        tick();
        cfg_rdy = 1'b0;
        wr_vld = 4'b0100; wr_rdy = 4'b0100;
        tick();
        wr_vld = '0; wr_rdy = '0;
        tick();
        chk("t5_done_pulse", 32'(done), 32'd1);
        tick();

        // Saturation on the 4-bit instance: 20 read beats -> 15
        n_vld = 1'b1;
        tick();
        n_vld = 1'b0; n_cfg_rdy = 1'b1; n_busy = 1'b1;
        tick();
        n_cfg_rdy = 1'b0;
        n_rd_vld = 14'h1; n_rd_rdy = 14'h1;
        repeat (20) tick();
        n_rd_vld = '0; n_rd_rdy = '0; n_busy = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (n_done) seen = 1'b1;
        end
        chk("t6_done_seen", 32'(seen), 32'd1);
        tick();
        chk("t6_rd_saturated", 32'(n_ro[RoRdBeats]), 32'd15);
        chk("t6_cyc_saturated", 32'(n_ro[RoCycles]), 32'd15);
        chk("t6_wr_zero", 32'(n_ro[RoWrBeats]), 32'd0);

        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("cfg_drained", 32'(cfg_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
